// File: rtl/transfer_reg_serial_if.sv
// Bus bundle for the serial-to-parallel transfer register.
//
// Strobe semantics: BIT_STB is a one-cycle qualifier. SDATA, SPAR and
// SYL_START carry meaning only on a cycle where BIT_STB=1. There is no
// back-pressure on the serial side. HOLD is a level that defers the
// parallel load, and TRVALID is a one-cycle pulse that marks a new TRV
// value. STATE_DBG mirrors the internal FSM state.
interface transfer_reg_serial_if;
  logic        BIT_STB;
  logic        SYL_START;
  logic        SDATA;
  logic        SPAR;
  logic        HOLD;
  logic        PERR_CLR;
  logic [12:0] TRV;
  logic        TRVALID;
  logic        BUSY;
  logic        PERR;
  logic        OVR;
  logic [3:0]  ERRCNT;
  logic [1:0]  STATE_DBG;

  // Producer of the serial stream and consumer of the parallel word
  modport master (
    output BIT_STB, SYL_START, SDATA, SPAR, HOLD, PERR_CLR,
    input  TRV, TRVALID, BUSY, PERR, OVR, ERRCNT, STATE_DBG
  );

  // The transfer register itself
  modport slave (
    input  BIT_STB, SYL_START, SDATA, SPAR, HOLD, PERR_CLR,
    output TRV, TRVALID, BUSY, PERR, OVR, ERRCNT, STATE_DBG
  );
endinterface

// File: rtl/transfer_reg_serial.sv
// Serial-to-parallel transfer register. It shifts in 13 data bits (TR1
// first, into TRV[0]) and then one parity bit. A good syllable is copied
// to TRV, or deferred while HOLD is high. A bad syllable sets the sticky
// error flags. The shadow register stays internal, so TRV only changes
// on a TRVALID edge.
module transfer_reg_serial #(
  parameter bit PARITY_ODD = 1'b1
) (
  input logic                   CLK,
  input logic                   RESET,
  transfer_reg_serial_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    WAIT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] shadow_q, shadow_d;
  logic [3:0]  count_q, count_d;
  logic [12:0] trv_q, trv_d;
  logic        trvalid_q, trvalid_d;
  logic        perr_q, perr_d;
  logic        ovr_q, ovr_d;
  logic [3:0]  errcnt_q, errcnt_d;
  logic        perr_set;
  logic        ovr_set;
  logic        start;
  logic        parity_ok;

  // A new syllable is only recognised when it coincides with a bit strobe
  assign start     = bus.BIT_STB & bus.SYL_START;
  assign parity_ok = ((^shadow_q) ^ bus.SPAR) == PARITY_ODD;

  // Next-state, datapath and flag update
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    count_d   = count_q;
    trv_d     = trv_q;
    trvalid_d = 1'b0;
    perr_set  = 1'b0;
    ovr_set   = 1'b0;
    errcnt_d  = errcnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = {12'd0, bus.SDATA};
          count_d  = 4'd1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          ovr_set  = 1'b1;
          shadow_d = {12'd0, bus.SDATA};
          count_d  = 4'd1;
        end else if (bus.BIT_STB) begin
          shadow_d[count_q] = bus.SDATA;
          count_d           = count_q + 4'd1;
          if (count_q == 4'd12) state_d = PAR;
        end
      end
      PAR: begin
        if (start) begin
          ovr_set  = 1'b1;
          shadow_d = {12'd0, bus.SDATA};
          count_d  = 4'd1;
          state_d  = SHIFT;
        end else if (bus.BIT_STB) begin
          if (!parity_ok) begin
            perr_set = 1'b1;
            if (errcnt_q != 4'hF) errcnt_d = errcnt_q + 4'd1;
            state_d = IDLE;
          end else if (bus.HOLD) begin
            state_d = WAIT;
          end else begin
            trv_d     = shadow_q;
            trvalid_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WAIT: begin
        if (start) begin
          ovr_set  = 1'b1;
          shadow_d = {12'd0, bus.SDATA};
          count_d  = 4'd1;
          state_d  = SHIFT;
        end else if (!bus.HOLD) begin
          trv_d     = shadow_q;
          trvalid_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new error in the same cycle as a clear leaves the flag set
    perr_d = perr_set | (perr_q & ~bus.PERR_CLR);
    ovr_d  = ovr_set  | (ovr_q  & ~bus.PERR_CLR);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      shadow_q  <= 13'd0;
      count_q   <= 4'd0;
      trv_q     <= 13'd0;
      trvalid_q <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      errcnt_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      count_q   <= count_d;
      trv_q     <= trv_d;
      trvalid_q <= trvalid_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign bus.TRV       = trv_q;
  assign bus.TRVALID   = trvalid_q;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.PERR      = perr_q;
  assign bus.OVR       = ovr_q;
  assign bus.ERRCNT    = errcnt_q;
  assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_transfer_reg_serial.sv
// Directed bench for transfer_reg_serial (PARITY_ODD=1).
module tb_transfer_reg_serial;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PAR   = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic CLK;
  logic RESET;
  int   vectors;
  int   miscompares;

  transfer_reg_serial_if bus ();

  transfer_reg_serial #(.PARITY_ODD(1'b1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Clock and overall time bound
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish, obs=running exp=done");
    $fatal(1, "timeout");
  end

  // Driver tasks: inputs change on the falling edge
  task automatic strobe(input logic sd, input logic ss, input logic sp);
    @(negedge CLK);
    bus.BIT_STB   = 1'b1;
    bus.SDATA     = sd;
    bus.SYL_START = ss;
    bus.SPAR      = sp;
    @(negedge CLK);
    bus.BIT_STB   = 1'b0;
    bus.SDATA     = 1'b0;
    bus.SYL_START = 1'b0;
    bus.SPAR      = 1'b0;
  endtask

  task automatic send_bits(input logic [12:0] value, input int lo, input int hi,
                           input logic with_start);
    for (int i = lo; i <= hi; i++)
      strobe(value[i], with_start && (i == lo), 1'b0);
  endtask

  task automatic send_par(input logic sp);
    strobe(1'b0, 1'b0, sp);
  endtask

  task automatic clr_pulse();
    @(negedge CLK);
    bus.PERR_CLR = 1'b1;
    @(negedge CLK);
    bus.PERR_CLR = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    RESET         = 1'b1;
    bus.BIT_STB   = 1'b0;
    bus.SYL_START = 1'b0;
    bus.SDATA     = 1'b0;
    bus.SPAR      = 1'b0;
    bus.HOLD      = 1'b0;
    bus.PERR_CLR  = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    // Reset state
    chk("rst_trv",     32'(bus.TRV),       32'h0);
    chk("rst_trvalid", 32'(bus.TRVALID),   32'h0);
    chk("rst_busy",    32'(bus.BUSY),      32'h0);
    chk("rst_perr",    32'(bus.PERR),      32'h0);
    chk("rst_ovr",     32'(bus.OVR),       32'h0);
    chk("rst_errcnt",  32'(bus.ERRCNT),    32'h0);
    chk("rst_state",   32'(bus.STATE_DBG), 32'(S_IDLE));

    // Strobe without SYL_START in IDLE is ignored
    strobe(1'b1, 1'b0, 1'b0);
    chk("idle_ignore", 32'(bus.STATE_DBG), 32'(S_IDLE));

    // Clean syllable 0x0A5B, good parity, no hold
    send_bits(13'h0A5B, 0, 12, 1'b1);
    chk("t1_state_par", 32'(bus.STATE_DBG), 32'(S_PAR));
    chk("t1_busy",      32'(bus.BUSY),      32'h1);
    chk("t1_pre_valid", 32'(bus.TRVALID),   32'h0);
    chk("t1_pre_trv",   32'(bus.TRV),       32'h0);
    send_par(1'b0);
    chk("t1_valid",     32'(bus.TRVALID),   32'h1);
    chk("t1_trv",       32'(bus.TRV),       32'h0A5B);
    chk("t1_perr",      32'(bus.PERR),      32'h0);
    chk("t1_idle",      32'(bus.STATE_DBG), 32'(S_IDLE));
    @(negedge CLK);
    chk("t1_valid_off", 32'(bus.TRVALID),   32'h0);

    // 0x1FFF held off for 5 cycles after the parity strobe
    bus.HOLD = 1'b1;
    send_bits(13'h1FFF, 0, 12, 1'b1);
    send_par(1'b0);
    chk("t3_wait",  32'(bus.STATE_DBG), 32'(S_WAIT));
    chk("t3_busy",  32'(bus.BUSY),      32'h1);
    chk("t3_trv",   32'(bus.TRV),       32'h0A5B);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("t3_hold_novalid", 32'(bus.TRVALID), 32'h0);
    end
    bus.HOLD = 1'b0;
    @(negedge CLK);
    chk("t3_valid",     32'(bus.TRVALID),   32'h1);
    chk("t3_trv_load",  32'(bus.TRV),       32'h1FFF);
    chk("t3_idle",      32'(bus.STATE_DBG), 32'(S_IDLE));
    @(negedge CLK);
    chk("t3_valid_off", 32'(bus.TRVALID),   32'h0);

    // Same 0x0A5B with wrong parity bit
    send_bits(13'h0A5B, 0, 12, 1'b1);
    send_par(1'b1);
    chk("t2_novalid", 32'(bus.TRVALID),   32'h0);
    chk("t2_trv",     32'(bus.TRV),       32'h1FFF);
    chk("t2_perr",    32'(bus.PERR),      32'h1);
    chk("t2_errcnt",  32'(bus.ERRCNT),    32'h1);
    chk("t2_idle",    32'(bus.STATE_DBG), 32'(S_IDLE));
    clr_pulse();
    chk("t2_clr_perr",   32'(bus.PERR),   32'h0);
    chk("t2_clr_errcnt", 32'(bus.ERRCNT), 32'h1);

    // Restart at bit 7, then a complete 0x0001
    send_bits(13'h0ABC, 0, 5, 1'b1);
    chk("t4_shift",  32'(bus.STATE_DBG), 32'(S_SHIFT));
    chk("t4_ovr0",   32'(bus.OVR),       32'h0);
    send_bits(13'h0001, 0, 0, 1'b1);
    chk("t4_ovr1",   32'(bus.OVR),       32'h1);
    chk("t4_shift2", 32'(bus.STATE_DBG), 32'(S_SHIFT));
    send_bits(13'h0001, 1, 12, 1'b0);
    send_par(1'b0);
    chk("t4_valid",  32'(bus.TRVALID),   32'h1);
    chk("t4_trv",    32'(bus.TRV),       32'h0001);
    chk("t4_perr",   32'(bus.PERR),      32'h0);

    // New syllable while WAIT discards the pending 0x1FFF
    clr_pulse();
    bus.HOLD = 1'b1;
    send_bits(13'h1FFF, 0, 12, 1'b1);
    send_par(1'b0);
    chk("t5_wait", 32'(bus.STATE_DBG), 32'(S_WAIT));
    send_bits(13'h0A5B, 0, 0, 1'b1);
    chk("t5_ovr",     32'(bus.OVR),       32'h1);
    chk("t5_shift",   32'(bus.STATE_DBG), 32'(S_SHIFT));
    chk("t5_novalid", 32'(bus.TRVALID),   32'h0);
    bus.HOLD = 1'b0;
    @(negedge CLK);
    chk("t5_novalid2", 32'(bus.TRVALID),  32'h0);
    send_bits(13'h0A5B, 1, 12, 1'b0);
    chk("t5_trv_kept", 32'(bus.TRV),      32'h0001);
    send_par(1'b0);
    chk("t5_valid",    32'(bus.TRVALID),  32'h1);
    chk("t5_trv",      32'(bus.TRV),      32'h0A5B);

    // 17 bad syllables saturate the error count (it starts at 1)
    clr_pulse();
    for (int n = 0; n < 17; n++) begin
      send_bits(13'h0A5B, 0, 12, 1'b1);
      send_par(1'b1);
    end
    chk("t6_errcnt_sat", 32'(bus.ERRCNT), 32'hF);
    chk("t6_perr",       32'(bus.PERR),   32'h1);
    chk("t6_trv",        32'(bus.TRV),    32'h0A5B);
    clr_pulse();
    chk("t6_clr_perr",   32'(bus.PERR),   32'h0);
    chk("t6_clr_ovr",    32'(bus.OVR),    32'h0);
    chk("t6_clr_errcnt", 32'(bus.ERRCNT), 32'hF);

    // Clear on the same edge as a new error: the error wins
    send_bits(13'h0A5B, 0, 12, 1'b1);
    bus.PERR_CLR = 1'b1;
    send_par(1'b1);
    bus.PERR_CLR = 1'b0;
    chk("t7_set_wins", 32'(bus.PERR), 32'h1);

    // Reset at bit 10 of a syllable, then a clean 0x0A5B
    send_bits(13'h1234, 0, 8, 1'b1);
    chk("t8_shift", 32'(bus.STATE_DBG), 32'(S_SHIFT));
    @(negedge CLK);
    RESET       = 1'b1;
    bus.BIT_STB = 1'b1;
    bus.SDATA   = 1'b1;
    @(negedge CLK);
    RESET       = 1'b0;
    bus.BIT_STB = 1'b0;
    bus.SDATA   = 1'b0;
    chk("t8_trv",     32'(bus.TRV),       32'h0);
    chk("t8_trvalid", 32'(bus.TRVALID),   32'h0);
    chk("t8_busy",    32'(bus.BUSY),      32'h0);
    chk("t8_perr",    32'(bus.PERR),      32'h0);
    chk("t8_ovr",     32'(bus.OVR),       32'h0);
    chk("t8_errcnt",  32'(bus.ERRCNT),    32'h0);
    chk("t8_state",   32'(bus.STATE_DBG), 32'(S_IDLE));
    send_bits(13'h0A5B, 0, 12, 1'b1);
    send_par(1'b0);
    chk("t8_valid",   32'(bus.TRVALID),   32'h1);
    chk("t8_trv_ld",  32'(bus.TRV),       32'h0A5B);
    chk("t8_ovr_ld",  32'(bus.OVR),       32'h0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
